// File: rtl/calc_input_sequencer.sv
// calc_input_sequencer: synchronizes switches/buttons and steps the X -> Y -> M -> READY entry sequence.
// Optional macro DEBOUNCE_EN adds per-button debounce counters (DEBOUNCE_CYCLES stable cycles).
module calc_input_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic [3:0] M,
    output logic       Control,
    output logic [1:0] stage
);
    localparam int unsigned SW_W  = 4;
    localparam int unsigned N_BTN = 2;

    typedef enum logic [1:0] {
        GET_X = 2'b00,
        GET_Y = 2'b01,
        GET_M = 2'b10,
        READY = 2'b11
    } state_t;

    logic [SW_W-1:0]        sw_sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] ent_sync_q;
    logic [SYNC_STAGES-1:0] clr_sync_q;
    logic [SW_W-1:0]        sw_s;
    logic [N_BTN-1:0]       btn_s;
    logic [N_BTN-1:0]       db_lvl;
    logic [N_BTN-1:0]       db_prev_q;
    logic [N_BTN-1:0]       pulse;

    state_t          state_q, state_d;
    logic [SW_W-1:0] x_q, x_d, y_q, y_d, m_q, m_d;
    logic            control_q, control_d;

    // Input synchronizers
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
            ent_sync_q <= '0;
            clr_sync_q <= '0;
        end else begin
            sw_sync_q[0]  <= sw;
            ent_sync_q[0] <= btn_enter;
            clr_sync_q[0] <= btn_clear;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync_q[i]  <= sw_sync_q[i-1];
                ent_sync_q[i] <= ent_sync_q[i-1];
                clr_sync_q[i] <= clr_sync_q[i-1];
            end
        end
    end

    assign sw_s  = sw_sync_q[SYNC_STAGES-1];
    assign btn_s = {clr_sync_q[SYNC_STAGES-1], ent_sync_q[SYNC_STAGES-1]};

`ifdef DEBOUNCE_EN
    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [N_BTN-1:0] db_q;
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [CNT_W-1:0] cnt_inc [N_BTN];

    always_comb begin
        for (int b = 0; b < N_BTN; b++)
            cnt_inc[b] = (cnt_q[b] == CNT_MAX) ? cnt_q[b] : cnt_q[b] + CNT_W'(1);
    end

    // Level flips only after CNT_MAX consecutive differing cycles; any reversion restarts the count
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            db_q <= '0;
            for (int b = 0; b < N_BTN; b++) cnt_q[b] <= '0;
        end else begin
            for (int b = 0; b < N_BTN; b++) begin
                if (btn_s[b] == db_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_inc[b] == CNT_MAX) begin
                    db_q[b]  <= btn_s[b];
                    cnt_q[b] <= '0;
                end else begin
                    cnt_q[b] <= cnt_inc[b];
                end
            end
        end
    end

    assign db_lvl = db_q;
`else
    assign db_lvl = btn_s;
`endif

    // Rising-edge detect: bit 0 is enter, bit 1 is clear
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) db_prev_q <= '0;
        else        db_prev_q <= db_lvl;
    end

    assign pulse = db_lvl & ~db_prev_q;

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            state_q   <= GET_X;
            x_q       <= '0;
            y_q       <= '0;
            m_q       <= '0;
            control_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            m_q       <= m_d;
            control_q <= control_d;
        end
    end

    // Clear wins over a coincident enter
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        m_d     = m_q;
        if (pulse[1]) begin
            state_d = GET_X;
            x_d     = '0;
            y_d     = '0;
            m_d     = '0;
        end else if (pulse[0]) begin
            case (state_q)
                GET_X: begin x_d = sw_s; state_d = GET_Y; end
                GET_Y: begin y_d = sw_s; state_d = GET_M; end
                GET_M: begin m_d = sw_s; state_d = READY; end
                READY: state_d = GET_X;
                default: state_d = GET_X;
            endcase
        end
        control_d = (state_d == READY);
    end

    assign X       = x_q;
    assign Y       = y_q;
    assign M       = m_q;
    assign Control = control_q;
    assign stage   = state_q;
endmodule

// File: tb/tb_calc_input_sequencer.sv
// tb_calc_input_sequencer: directed + random stimulus against an entry-count reference model.
module tb_calc_input_sequencer;
    localparam int unsigned DB_CYC = 4;
    localparam int unsigned SYNC   = 2;
`ifdef DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic [3:0] sw        = '0;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] X, Y, M;
    logic       Control;
    logic [1:0] stage;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    calc_input_sequencer #(.DEBOUNCE_CYCLES(DB_CYC), .SYNC_STAGES(SYNC)) dut (
        .clock_100Mhz(clk), .reset(reset), .sw(sw),
        .btn_enter(btn_enter), .btn_clear(btn_clear),
        .X(X), .Y(Y), .M(M), .Control(Control), .stage(stage)
    );

    // Model: m_idx counts completed entries (0..3); m_op holds the operands in entry order.
    logic [3:0]      m_swp [SYNC];
    logic [SYNC-1:0] m_bp  [2];
    bit              m_db  [2];
    bit              m_prv [2];
    int              m_cnt [2];
    int              m_idx = 0;
    logic [3:0]      m_op  [3];

    initial begin
        for (int i = 0; i < SYNC; i++) m_swp[i] = '0;
        for (int b = 0; b < 2; b++) begin
            m_bp[b] = '0; m_db[b] = 0; m_prv[b] = 0; m_cnt[b] = 0;
        end
        for (int k = 0; k < 3; k++) m_op[k] = '0;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC; i++) m_swp[i] = '0;
            for (int b = 0; b < 2; b++) begin
                m_bp[b] = '0; m_db[b] = 0; m_prv[b] = 0; m_cnt[b] = 0;
            end
            for (int k = 0; k < 3; k++) m_op[k] = '0;
            m_idx = 0;
        end else begin
            bit lvl [2];
            bit pls [2];
            for (int b = 0; b < 2; b++) begin
                lvl[b] = DB_ON ? m_db[b] : m_bp[b][SYNC-1];
                pls[b] = lvl[b] && !m_prv[b];
            end
            if (pls[1]) begin
                m_idx = 0;
                for (int k = 0; k < 3; k++) m_op[k] = '0;
            end else if (pls[0]) begin
                if (m_idx == 3) m_idx = 0;
                else begin
                    m_op[m_idx] = m_swp[SYNC-1];
                    m_idx++;
                end
            end
            for (int b = 0; b < 2; b++) begin
                m_prv[b] = lvl[b];
                if (m_bp[b][SYNC-1] != m_db[b]) begin
                    m_cnt[b]++;
                    if (m_cnt[b] == DB_CYC) begin
                        m_db[b]  = !m_db[b];
                        m_cnt[b] = 0;
                    end
                end else m_cnt[b] = 0;
            end
            for (int i = SYNC - 1; i > 0; i--) m_swp[i] = m_swp[i-1];
            m_swp[0] = sw;
            m_bp[0]  = {m_bp[0][SYNC-2:0], btn_enter};
            m_bp[1]  = {m_bp[1][SYNC-2:0], btn_clear};
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("X", 8'(X), 8'(m_op[0]));
        chk("Y", 8'(Y), 8'(m_op[1]));
        chk("M", 8'(M), 8'(m_op[2]));
        chk("Control", 8'(Control), 8'(m_idx == 3));
        chk("stage", 8'(stage), 8'(m_idx));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_enter(input logic [3:0] v, input int hold);
        sw = v; cyc(1);
        btn_enter = 1'b1; cyc(hold);
        btn_enter = 1'b0; cyc(10);
    endtask

    task automatic press_clear(input int hold);
        btn_clear = 1'b1; cyc(hold);
        btn_clear = 1'b0; cyc(10);
    endtask

    task automatic lit(input string name, input logic [3:0] ex, input logic [3:0] ey,
                       input logic [3:0] em, input logic ec, input logic [1:0] es);
        chk({name, "_X"}, 8'(X), 8'(ex));
        chk({name, "_Y"}, 8'(Y), 8'(ey));
        chk({name, "_M"}, 8'(M), 8'(em));
        chk({name, "_Control"}, 8'(Control), 8'(ec));
        chk({name, "_stage"}, 8'(stage), 8'(es));
    endtask

    initial begin
        cyc(3);
        lit("reset", 4'd0, 4'd0, 4'd0, 1'b0, 2'd0);
        reset = 1'b1;
        cyc(2);

        press_enter(4'd3, 10);
        press_enter(4'd5, 10);
        press_enter(4'd2, 10);
        lit("clean", 4'd3, 4'd5, 4'd2, 1'b1, 2'd3);
        chk("model_idx", 8'(m_idx), 8'd3);

        press_clear(10);
        lit("clear", 4'd0, 4'd0, 4'd0, 1'b0, 2'd0);

        sw = 4'd9; cyc(1);
        btn_enter = 1'b1; cyc(1);
        btn_enter = 1'b0; cyc(1);
        btn_enter = 1'b1; cyc(1);
        cyc(10);
        btn_enter = 1'b0; cyc(10);
`ifdef DEBOUNCE_EN
        lit("bounce", 4'd9, 4'd0, 4'd0, 1'b0, 2'd1);

        sw = 4'd6; cyc(1);
        btn_enter = 1'b1; cyc(50);
        lit("held", 4'd9, 4'd6, 4'd0, 1'b0, 2'd2);
        btn_enter = 1'b0; cyc(10);
        chk("held_release_stage", 8'(stage), 8'd2);
        press_enter(4'd1, 10);
        lit("second", 4'd9, 4'd6, 4'd1, 1'b1, 2'd3);
`else
        press_enter(4'd1, 10);
`endif

        btn_enter = 1'b1; btn_clear = 1'b1; cyc(10);
        btn_enter = 1'b0; btn_clear = 1'b0; cyc(10);
        lit("coincide", 4'd0, 4'd0, 4'd0, 1'b0, 2'd0);

        press_enter(4'd3, 10);
        press_enter(4'd5, 10);
        lit("pre_reset", 4'd3, 4'd5, 4'd0, 1'b0, 2'd2);
        @(posedge clk); #2;
        reset = 1'b0; #1;
        lit("async_reset", 4'd0, 4'd0, 4'd0, 1'b0, 2'd0);
        #1 reset = 1'b1;
        cyc(3);
        lit("post_reset", 4'd0, 4'd0, 4'd0, 1'b0, 2'd0);

        press_enter(4'd3, 10);
        repeat (100) begin sw = ~sw; cyc(1); end
        cyc(5);
        lit("sw_noise", 4'd3, 4'd0, 4'd0, 1'b0, 2'd1);

        repeat (150) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 5) begin
                sw = 4'($urandom); cyc(1);
                repeat ($urandom_range(0, 3)) begin
                    btn_enter = ~btn_enter; cyc(1);
                end
                btn_enter = 1'b1; cyc(int'($urandom_range(1, 12)));
                btn_enter = 1'b0; cyc(int'($urandom_range(0, 12)));
            end else if (r == 6) begin
                btn_clear = 1'b1; cyc(int'($urandom_range(1, 10)));
                btn_clear = 1'b0; cyc(int'($urandom_range(0, 10)));
            end else if (r == 7) begin
                sw = 4'($urandom);
                btn_enter = 1'b1; btn_clear = 1'b1; cyc(int'($urandom_range(2, 10)));
                btn_enter = 1'b0; btn_clear = 1'b0; cyc(int'($urandom_range(0, 10)));
            end else if (r == 8) begin
                repeat ($urandom_range(5, 20)) begin sw = 4'($urandom); cyc(1); end
            end else begin
                @(posedge clk); #2;
                reset = 1'b0; #2;
                reset = 1'b1;
                cyc(int'($urandom_range(1, 5)));
            end
        end
        cyc(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/calc_input_sequencer.md
CALC_INPUT_SEQUENCER -- requirements
Module: calc_input_sequencer

Interface
REQ-001 The block SHALL provide parameter DEBOUNCE_CYCLES, default 1000000, the consecutive stable cycles needed to accept a button level change.
REQ-002 The block SHALL provide parameter SYNC_STAGES, default 2, the flip-flop stages on each asynchronous input.
REQ-003 Port clock_100Mhz  input  1  the single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port sw  input  4  raw operand/opcode switch value.
REQ-006 Port btn_enter  input  1  raw, bouncy "enter" pushbutton, active-high.
REQ-007 Port btn_clear  input  1  raw, bouncy "clear" pushbutton, active-high.
REQ-008 Port X  output  4  latched first operand, to the calculator X input.
REQ-009 Port Y  output  4  latched second operand, to the calculator Y input.
REQ-010 Port M  output  4  latched mode/opcode, to the calculator M input.
REQ-011 Port Control  output  1  high while X, Y and M are all valid (state READY).
REQ-012 Port stage  output  2  current state encoding, for status LEDs.

Function
REQ-013 sw, btn_enter and btn_clear SHALL each pass through a SYNC_STAGES-deep synchronizer before any other use.
REQ-014 The FSM SHALL have states GET_X (stage=00), GET_Y (01), GET_M (10) and READY (11).
REQ-015 enter_pulse SHALL be a one-cycle pulse on each rising edge of the debounced enter level; clear_pulse SHALL be the same for clear.
REQ-016 A held button SHALL produce exactly one pulse; release SHALL produce none.
REQ-017 On enter_pulse in GET_X, X SHALL load the synchronized sw and the state SHALL become GET_Y on the same edge.
REQ-018 On enter_pulse in GET_Y, Y SHALL load sw and the state SHALL become GET_M.
REQ-019 On enter_pulse in GET_M, M SHALL load sw, the state SHALL become READY, and Control SHALL be 1 from that edge.
REQ-020 On enter_pulse in READY, the state SHALL become GET_X and Control SHALL drop to 0 on the same edge.
REQ-021 X, Y and M SHALL hold their values through that READY-to-GET_X transition until each is overwritten.
REQ-022 On clear_pulse in any state, the state SHALL become GET_X and X, Y, M and Control SHALL become 0.
REQ-023 clear_pulse SHALL take priority when it coincides with enter_pulse; the enter SHALL be discarded.
REQ-024 Changes on sw without an enter_pulse SHALL never alter X, Y or M.
REQ-025 Control SHALL be a registered output, equal to (state == READY).
REQ-026 The debounce counter SHALL saturate and SHALL never wrap.

Reset
REQ-027 While reset=0, the block SHALL asynchronously force state to GET_X, X/Y/M to 0 and Control to 0.
REQ-028 While reset=0, the block SHALL also clear synchronizers, debounced levels and counters to 0.
REQ-029 Deassertion of reset SHALL take effect at the next clock edge.
REQ-030 A button held across reset release SHALL produce a pulse only after it has been debounced as high.
REQ-031 Reset mid-sequence SHALL discard any partial entry.

Configuration
REQ-032 Macro DEBOUNCE_EN SHALL control the debounce counters.
REQ-033 With DEBOUNCE_EN defined, a button's debounced level SHALL change only after its synchronized level differs from the debounced level for DEBOUNCE_CYCLES consecutive cycles.
REQ-034 With DEBOUNCE_EN defined, any reversion during that window SHALL reset the counter to 0.
REQ-035 With DEBOUNCE_EN defined, enter_pulse SHALL assert in the cycle after the debounced level rises.
REQ-036 Without DEBOUNCE_EN, the debounced level SHALL equal the synchronized level, no counters SHALL exist, and DEBOUNCE_CYCLES SHALL be ignored.

Verification (DEBOUNCE_EN defined, DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-037 Bench SHALL cover: sw=3,enter; sw=5,enter; sw=2,enter (clean presses) -> X=3, Y=5, M=2, Control=1, stage=11.
REQ-038 Bench SHALL cover: enter toggled 1/0 every cycle for 3 cycles, then held high for 10 cycles -> exactly one X load; stage 00 to 01 once.
REQ-039 Bench SHALL cover: enter held high 50 cycles in GET_Y -> only Y loads; state stays GET_M until release and a second press.
REQ-040 Bench SHALL cover: in READY, enter and clear rise on the same cycle -> stage=00, X=Y=M=0, Control=0.
REQ-041 Bench SHALL cover: in GET_M with X=3 and Y=5, reset pulsed low between clock edges -> outputs zero immediately, before the next edge; stage=00.
REQ-042 Bench SHALL cover: sw toggling every cycle with no button activity for 100 cycles -> X, Y, M unchanged.
